multdiv_unit: RTL

Multi-cycle multiply/divide unit for the MIPS core. It accepts one `multicycle_t` operation (MULT, MULTU, DIV, DIVU) at a time from the execute stage. Multiplies complete in one cycle and divides use a 32-iteration restoring divider. The unit returns the HI/LO pair as two `hilo_write_req` records for the HI/LO register file. It sits beside the ALU in execute and stalls the pipeline through a valid/ready handshake.

---
 rtl/multdiv_unit.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/multdiv_unit.sv
// Multi-cycle multiply/divide unit: single-cycle multiply, 32-step restoring divide,
// HI/LO results held until the consumer takes them.
package multdiv_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {M_MULT, M_MULTU, M_DIV, M_DIVU} multicycle_t;
  typedef struct packed {
    logic  valid;
    word_t data;
  } hilo_write_req;
endpackage

module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  multicycle_t   in_op,
  input  word_t         in_a,
  input  word_t         in_b,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output hilo_write_req out_hi,
  output hilo_write_req out_lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state_q, state_d;
  multicycle_t op_q, op_d;
  logic        neg_q, neg_d;
  logic        neg_a_q, neg_a_d;
  logic        dz_q, dz_d;
  word_t       hi_q, hi_d;
  word_t       lo_q, lo_d;
  word_t       b_q, b_d;
  logic [5:0]  iter_q, iter_d;

  logic        accept;
  logic        op_signed, op_is_div, op_dz, sign_a, sign_b;
  logic [32:0] rem, rem_sub;
  logic        rem_ge;
  logic [63:0] prod, mul_res;
  word_t       quo_fix, rem_fix;

  assign accept    = in_valid && in_ready && !flush;
  assign op_signed = (in_op == M_MULT) || (in_op == M_DIV);
  assign op_is_div = in_op[1];
  assign op_dz     = op_is_div && (in_b == 32'd0);
  assign sign_a    = op_signed && in_a[31];
  assign sign_b    = op_signed && in_b[31];

  // lo_q doubles as the dividend shift register and fills with quotient bits
  assign rem     = {hi_q, lo_q[31]};
  assign rem_ge  = rem >= {1'b0, b_q};
  assign rem_sub = rem - {1'b0, b_q};
  assign prod    = 64'(lo_q) * 64'(b_q);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg_d   = neg_q;
    neg_a_d = neg_a_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    iter_d  = iter_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = in_op;
          neg_d   = sign_a ^ sign_b;
          neg_a_d = sign_a;
          dz_d    = op_dz;
          // a divide by zero keeps the raw dividend so the remainder comes out as a
          lo_d    = (sign_a && !op_dz) ? -in_a : in_a;
          b_d     = sign_b ? -in_b : in_b;
          hi_d    = 32'd0;
          iter_d  = 6'd0;
          state_d = op_is_div ? DIV : MUL;
        end
      end
      MUL: begin
        {hi_d, lo_d} = prod;
        state_d      = DONE;
      end
      DIV: begin
        hi_d   = rem_ge ? rem_sub[31:0] : rem[31:0];
        lo_d   = {lo_q[30:0], rem_ge};
        iter_d = iter_q + 6'd1;
        if (iter_q == 6'(DIV_CYCLES - 1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush && state_q != IDLE) begin
      state_d = IDLE;
      iter_d  = 6'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= M_MULT;
      neg_q   <= 1'b0;
      neg_a_q <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      b_q     <= 32'd0;
      iter_q  <= 6'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      neg_a_q <= neg_a_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      b_q     <= b_d;
      iter_q  <= iter_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  assign mul_res = (op_q == M_MULT && neg_q) ? -{hi_q, lo_q} : {hi_q, lo_q};
  assign quo_fix = (neg_q && !dz_q) ? -lo_q : lo_q;
  assign rem_fix = (neg_a_q && !dz_q) ? -hi_q : hi_q;

  // data is forced to zero outside DONE so the write requests are inert when not valid
  always_comb begin
    out_hi.valid = out_valid;
    out_lo.valid = out_valid;
    out_hi.data  = 32'd0;
    out_lo.data  = 32'd0;
    if (out_valid) begin
      out_hi.data = op_q[1] ? rem_fix : mul_res[63:32];
      out_lo.data = op_q[1] ? quo_fix : mul_res[31:0];
    end
  end

endmodule
